// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit_serializer block (package ser_pkg).
// The state encoding is shared so that checkers and neighbours can decode it.
package ser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int SER_WIDTH_DFLT = 8;

   // The bit counter must hold FRAME-1, which is at most WIDTH when the parity bit is appended
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Handshake and serial-line bundle for bit_serializer.
// The master side is the word producer and line observer; the slave side is the serializer.
interface bit_serializer_if
   import ser_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH_DFLT
);
   logic [WIDTH-1:0] din;
   logic             din_vld;
   logic             din_rdy;
   logic             out;
   logic             out_vld;
   logic             busy;

   modport master (
      output din, din_vld,
      input  din_rdy, out, out_vld, busy
   );

   modport slave (
      input  din, din_vld,
      output din_rdy, out, out_vld, busy
   );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage, MSB first, feeding a "1011" sequence detector.
// Build option SER_PARITY_EN appends an even-parity bit to every frame.
module bit_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH_DFLT,
   parameter int GAP   = 0
) (
   input  logic            clk,
   input  logic            rst,
   bit_serializer_if.slave bus
);

`ifdef SER_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);
   localparam bit            HAS_GAP  = (GAP > 32'sd0);
   localparam logic [7:0]    GAP_LOAD = HAS_GAP ? 8'(GAP - 1) : 8'd0;

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] shift_s;
   logic [CW-1:0]    bit_cnt_r;
   logic [CW-1:0]    bit_cnt_s;
   logic [7:0]       gap_cnt_r;
   logic [7:0]       gap_cnt_s;
   logic             din_rdy_s;
   logic             accept_s;
   logic             out_s;
   logic             out_r;
   logic             out_vld_r;
   logic             busy_r;

`ifdef SER_PARITY_EN
   logic parity_r;
   logic parity_s;

   function automatic logic even_parity(input logic [WIDTH-1:0] word);
      return ^word;
   endfunction
`endif

   // Ready is decoded from state and counters only and held low during reset
   always_comb begin
      din_rdy_s = 1'b0;
      if (rst) begin
         din_rdy_s = 1'b0;
      end else begin
         case (state_r)
            IDLE:         din_rdy_s = 1'b1;
            SHIFT:        din_rdy_s = (bit_cnt_r == CNT_ZERO) && !HAS_GAP;
            ser_pkg::GAP: din_rdy_s = 1'b0;
            default:      din_rdy_s = 1'b0;
         endcase
      end
   end

   assign accept_s = bus.din_vld & din_rdy_s;

   // Next-state, datapath and next-output decode; an accept always starts a fresh frame
   always_comb begin
      state_s   = state_r;
      shift_s   = shift_r;
      bit_cnt_s = bit_cnt_r;
      gap_cnt_s = gap_cnt_r;
`ifdef SER_PARITY_EN
      parity_s  = parity_r;
`endif
      if (accept_s) begin
         state_s   = SHIFT;
         shift_s   = bus.din;
         bit_cnt_s = LAST_CNT;
`ifdef SER_PARITY_EN
         parity_s  = even_parity(bus.din);
`endif
      end else begin
         case (state_r)
            IDLE: state_s = IDLE;
            SHIFT: begin
               if (bit_cnt_r != CNT_ZERO) begin
                  shift_s   = {shift_r[WIDTH-2:0], 1'b0};
                  bit_cnt_s = bit_cnt_r - CNT_ONE;
               end else if (HAS_GAP) begin
                  state_s   = ser_pkg::GAP;
                  gap_cnt_s = GAP_LOAD;
               end else begin
                  state_s   = IDLE;
               end
            end
            ser_pkg::GAP: begin
               if (gap_cnt_r == 8'd0) begin
                  state_s   = IDLE;
               end else begin
                  gap_cnt_s = gap_cnt_r - 8'd1;
               end
            end
            default: state_s = IDLE;
         endcase
      end

      // The line is forced to 0 outside SHIFT so the detector falls back to idle
      out_s = 1'b0;
      if (state_s == SHIFT) begin
`ifdef SER_PARITY_EN
         if (bit_cnt_s == CNT_ZERO) begin
            out_s = parity_s;
         end else begin
            out_s = shift_s[WIDTH-1];
         end
`else
         out_s = shift_s[WIDTH-1];
`endif
      end else begin
         out_s = 1'b0;
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         shift_r   <= {WIDTH{1'b0}};
         bit_cnt_r <= CNT_ZERO;
         gap_cnt_r <= 8'd0;
`ifdef SER_PARITY_EN
         parity_r  <= 1'b0;
`endif
         out_r     <= 1'b0;
         out_vld_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         shift_r   <= shift_s;
         bit_cnt_r <= bit_cnt_s;
         gap_cnt_r <= gap_cnt_s;
`ifdef SER_PARITY_EN
         parity_r  <= parity_s;
`endif
         out_r     <= out_s;
         out_vld_r <= (state_s == SHIFT);
         busy_r    <= (state_s != IDLE);
      end
   end

   assign bus.din_rdy = din_rdy_s;
   assign bus.out     = out_r;
   assign bus.out_vld = out_vld_r;
   assign bus.busy    = busy_r;

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage placed directly upstream of the "1011" Moore sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clk.
- The serial output drives the detector's `in`. `out_vld` marks cycles that carry real data bits.
- Between frames the serial line is held at 0, which returns the detector to its idle state.

Parameters:
- WIDTH, 8: data word width in bits; must be 2 or greater.
- GAP, 0: number of idle cycles inserted after each frame, with out=0 and out_vld=0. Legal range is 0 to 255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word to serialize.
- din_vld  input  1  din is valid.
- din_rdy  output  1  block can accept din this cycle.
- out  output  1  serial bit, MSB first; 0 whenever out_vld=0.
- out_vld  output  1  out carries a data bit (or the parity bit, when enabled).
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - out=0, out_vld=0, busy=0.
  - din_rdy is forced 0 while rst=1.
- Registered outputs: out, out_vld and busy are registers. din_rdy is combinational from state and counters only; it never depends on din_vld.
- Accept rule: a word is taken on a rising edge where din_vld=1 and din_rdy=1. din is ignored in every other cycle.
- Latency: the first bit (din[WIDTH-1]) appears on out with out_vld=1 in the cycle after the accept edge.
- FSM states are IDLE, SHIFT and GAP.
- IDLE:
  - din_rdy=1, out=0, out_vld=0.
  - On accept: load the shift register, set bit counter to FRAME-1, go to SHIFT.
- SHIFT:
  - out_vld=1 and out = shift register MSB.
  - The register shifts left each cycle and the counter decrements.
  - FRAME = WIDTH, or WIDTH+1 when parity is enabled.
  - Last bit cycle (counter=0):
    - If GAP>0: din_rdy=0; go to GAP with gap counter=GAP-1.
    - If GAP=0: din_rdy=1. An accept in this cycle reloads the register and stays in SHIFT, giving back-to-back frames with no idle cycle. With no accept, go to IDLE.
  - In all non-last SHIFT cycles, din_rdy=0.
- GAP:
  - out=0, out_vld=0, din_rdy=0.
  - Decrement the gap counter; at 0, go to IDLE.
- Counter widths: bit counter is $clog2(WIDTH+1) bits; gap counter is 8 bits. No wrap-around is permitted; all transitions occur exactly at 0.
- din_vld held high with din_rdy=0: the word is not consumed and the producer must hold it. A change of din during this time has no effect.
- Reset mid-frame: the remaining bits are discarded and out/out_vld go to 0 immediately. After rst deasserts, the next accept starts a clean frame.
- busy=1 in SHIFT and GAP.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - Each frame has WIDTH data bits followed by one even-parity bit, equal to the XOR of the accepted word.
  - The parity bit is emitted with out_vld=1, and FRAME = WIDTH+1.
  - The back-to-back accept occurs on the parity cycle.
  - Parity is computed at load time and stored in a 1-bit register.
- Undefined: FRAME = WIDTH, no parity logic is present, and the port list is unchanged.

Decomposition:
- Package ser_pkg holds:
  - the state typedef enum {IDLE, SHIFT, GAP}, 2 bits;
  - the default-width constant SER_WIDTH_DFLT=8;
  - a constant function giving the counter width from WIDTH.
- No sub-module: the FSM, shift register and counters are a single module. The downstream sequence detector stays a separate instance.

Test Plan:
1. Reset, then din=8'hB0 with a one-cycle din_vld.
   - out_vld is high for 8 cycles starting the cycle after accept.
   - out sequence is 1,0,1,1,0,0,0,0.
   - The chained detector output is high exactly one cycle, the cycle after the 4th bit.
2. GAP=0, din_vld held high with words 8'hA5 then 8'h3C.
   - out_vld is high for 16 contiguous cycles with bits 10100101 00111100.
   - din_rdy is 1 only on the 8th bit cycle and in IDLE.
3. GAP=2, two words sent back-to-back.
   - Exactly 2 cycles of out=0, out_vld=0, din_rdy=0 occur between frames.
   - The second frame starts one cycle after its accept.
4. rst asserted after 3 bits of 8'hFF.
   - out and out_vld drop to 0 asynchronously.
   - After release, din_rdy=1; word 8'h81 then serializes as 10000001.
5. During SHIFT, din_vld=1 with din toggled each cycle between 8'h00 and 8'hFF.
   - The frame in progress is unaffected.
   - The value present on the din_rdy cycle is the next word serialized.
6. SER_PARITY_EN defined.
   - 8'h07 gives a 9-bit frame whose 9th bit is 1.
   - 8'h03 gives a 9th bit of 0.
   - out_vld is high for 9 cycles per frame.
